// File: rtl/seq_divider_4_if.sv
// Request/response bundle for the sequential divider: valid/ready request carrying
// the operands, valid/ready response carrying quotient, remainder and divide-by-zero flag.
interface seq_divider_4_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_4.sv
// Multi-cycle restoring unsigned divider: one trial subtraction per cycle through a
// lookahead-carry adder (A + ~B + 1), WIDTH iterations per non-zero-divisor request.
module seq_divider_4 #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_4_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] q_sh_s;
    logic [WIDTH-1:0] r_new_s;

    function automatic logic [WIDTH:0] cla_add(
        input logic [WIDTH:0] a,
        input logic [WIDTH:0] b,
        input logic           cin
    );
        logic [WIDTH:0] g;
        logic [WIDTH:0] p;
        logic [WIDTH:0] c;
        g    = a & b;
        p    = a ^ b;
        c    = {(WIDTH + 1){1'b0}};
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

    // The shifted remainder keeps the bit leaving R so large divisors cannot overflow.
    assign r_sh_s  = {r_q, q_q[WIDTH-1]};
    assign trial_s = cla_add(r_sh_s, ~{1'b0, d_q}, 1'b1);
    assign q_sh_s  = {q_q[WIDTH-2:0], ~trial_s[WIDTH]};
    assign r_new_s = trial_s[WIDTH] ? r_sh_s[WIDTH-1:0] : trial_s[WIDTH-1:0];

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_d     = bus.dividend;
                        r_d     = {WIDTH{1'b0}};
                        d_d     = bus.divisor;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                q_d   = q_sh_s;
                r_d   = r_new_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_sh_s;
                    rem_d   = r_new_s;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= {WIDTH{1'b0}};
            r_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_seq_divider_4.sv
// Bench for seq_divider_4: vector table plus corner-case sequences, with expected
// results queued at request time and checked when the response handshake occurs.
module tb_seq_divider_4;
    logic clk;
    logic rst_n;

    seq_divider_4_if #(.WIDTH(4)) dif ();

    seq_divider_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         stall;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit reached, want run to complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response checker: pops the oldest expectation on each accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dif.out_valid && dif.out_ready) begin
                chk("in_ready_in_done", int'(dif.in_ready), 0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_result: got quotient %0d remainder %0d, want no result",
                             dif.quotient, dif.remainder);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", int'(dif.quotient), int'(e.q));
                    chk("remainder", int'(dif.remainder), int'(e.r));
                    chk("div_by_zero", int'(dif.div_by_zero), int'(e.z));
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input bit push,
                        input exp_t e);
        int t;
        t = 0;
        while (!dif.in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_before_accept", int'(dif.in_ready), 1);
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        tick();
        dif.in_valid = 1'b0;
        dif.dividend = 4'($urandom_range(0, 15));
        dif.divisor  = 4'($urandom_range(0, 15));
    endtask

    task automatic recv(input int stall, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        while (!dif.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!dif.out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        for (int i = 0; i < stall; i++) begin
            chk("stall_out_valid", int'(dif.out_valid), 1);
            chk("stall_in_ready", int'(dif.in_ready), 0);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("stall_quotient", int'(dif.quotient), int'(e.q));
                chk("stall_remainder", int'(dif.remainder), int'(e.r));
            end
            tick();
        end
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        chk("out_valid_after_accept", int'(dif.out_valid), 0);
        chk("in_ready_after_result", int'(dif.in_ready), 1);
    endtask

    task automatic quiet_check(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | dif.out_valid;
        end
        chk(name, int'(seen), 0);
    endtask

    initial begin
        vec_t tbl[9];
        exp_t e;
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, z: 1'b0, stall: 0};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0, stall: 0};
        tbl[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, z: 1'b0, stall: 1};
        tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0, stall: 0};
        tbl[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0, stall: 2};
        tbl[5] = '{a: 4'd8,  b: 4'd3,  q: 4'd2,  r: 4'd2, z: 1'b0, stall: 0};
        tbl[6] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9, z: 1'b1, stall: 0};
        tbl[7] = '{a: 4'd6,  b: 4'd2,  q: 4'd3,  r: 4'd0, z: 1'b0, stall: 0};
        tbl[8] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2, z: 1'b0, stall: 5};

        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.dividend  = 4'd0;
        dif.divisor   = 4'd0;
        dif.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_in_ready", int'(dif.in_ready), 1);
        chk("reset_out_valid", int'(dif.out_valid), 0);
        chk("reset_quotient", int'(dif.quotient), 0);
        chk("reset_remainder", int'(dif.remainder), 0);
        chk("reset_div_by_zero", int'(dif.div_by_zero), 0);

        for (int i = 0; i < 9; i++) begin
            e = '{q: tbl[i].q, r: tbl[i].r, z: tbl[i].z};
            send(tbl[i].a, tbl[i].b, 1'b1, e);
            recv(tbl[i].stall, tbl[i].z ? 0 : 4);
        end

        // Operand changes and a stray in_valid while busy must be ignored.
        send(4'd12, 4'd5, 1'b1, '{q: 4'd2, r: 4'd2, z: 1'b0});
        tick();
        dif.dividend = 4'd1;
        dif.divisor  = 4'd1;
        dif.in_valid = 1'b1;
        tick();
        dif.in_valid = 1'b0;
        recv(0, 2);
        quiet_check("no_extra_after_busy_pulse");

        // Reset on the second iteration edge abandons 11/2.
        send(4'd11, 4'd2, 1'b0, '{q: 4'd0, r: 4'd0, z: 1'b0});
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(dif.in_ready), 1);
        chk("midrst_out_valid", int'(dif.out_valid), 0);
        chk("midrst_quotient", int'(dif.quotient), 0);
        chk("midrst_remainder", int'(dif.remainder), 0);
        chk("midrst_div_by_zero", int'(dif.div_by_zero), 0);
        quiet_check("no_result_after_reset");
        send(4'd11, 4'd2, 1'b1, '{q: 4'd5, r: 4'd1, z: 1'b0});
        recv(0, 4);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) e = '{q: 4'hF, r: 4'(a), z: 1'b1};
                else        e = '{q: 4'(a / b), r: 4'(a % b), z: 1'b0};
                send(4'(a), 4'(b), 1'b1, e);
                recv($urandom_range(0, 2), (b == 0) ? 0 : 4);
            end
        end

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seq_divider_4.md
# seq_divider_4

Multi-cycle restoring unsigned divider. It divides a WIDTH-bit dividend by a WIDTH-bit divisor and returns the quotient and remainder. Each iteration does one trial subtraction, computed as A + ~B + 1 through a carry-lookahead adder path. The block is the subtract/divide counterpart to the team's 4-bit CLA adder and sits in the arithmetic datapath behind a valid/ready request port and a valid/ready response port.

## Interface
- WIDTH, 4, operand/result width in bits; legal range is 2 to 16.
- clk  in  1  single clock; everything updates on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  a request is present on dividend/divisor.
- in_ready  out  1  the block can accept a request; high only in IDLE.
- dividend  in  WIDTH  unsigned dividend.
- divisor  in  WIDTH  unsigned divisor.
- out_valid  out  1  the result is valid; high only in DONE.
- out_ready  in  1  the consumer accepts the result.
- quotient  out  WIDTH  unsigned quotient.
- remainder  out  WIDTH  unsigned remainder.
- div_by_zero  out  1  the divisor was 0; qualified by out_valid.

## Operation
- FSM states: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - Request accepted on an edge with in_valid=1.
  - dividend and divisor are latched on acceptance. Port values at any later time are ignored until the next acceptance.
- Accept with divisor≠0:
  - Load Q=dividend, R=0, D=divisor, iteration count=WIDTH.
  - Go to BUSY.
- Accept with divisor=0:
  - quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Go straight to DONE; no iterations run.
- BUSY, one iteration per edge:
  - {R,Q} ← {R,Q}<<1.
  - trial = {1'b0,R_shifted} + ~{1'b0,D} + 1, computed WIDTH+1 bits wide with lookahead carry.
  - If trial MSB=0 (no borrow): R=trial[WIDTH-1:0] and Q[0]=1.
  - Otherwise: R is unchanged and Q[0]=0.
  - Decrement the count. When the count reaches 0, load quotient=Q and remainder=R, set div_by_zero=0, and go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready=0 in DONE, even when out_ready=1 in the same cycle; no pass-through.
- Output registers keep their last values in IDLE and are meaningful only while out_valid=1.
- Invariant for a non-zero divisor: quotient*divisor + remainder = dividend, and remainder < divisor.

## Timing
- Reset: if rst_n=0 on an edge, the following all take effect on that edge:
  - state=IDLE, in_ready=1.
  - out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - Internal Q, R, D and count cleared.
- Reset during BUSY or DONE abandons the operation; no out_valid is produced for it.
- Reset overrides in_valid/out_ready on the same edge.
- Let E0 be the acceptance edge.
  - divisor≠0: iterations occur on E1..E_WIDTH. out_valid is high from after E_WIDTH, so the result is visible WIDTH cycles after acceptance (4 for WIDTH=4).
  - divisor=0: out_valid is high from after E0.
- out_valid stays high, and its outputs do not change, until the edge where out_ready=1. out_valid=0 after that edge.
- Minimum request spacing with out_ready tied high:
  - WIDTH+2 edges (accept, WIDTH iterations, one DONE cycle).
  - 2 edges for divide-by-zero.
- No combinational path from any input to any output; in_ready and out_valid are decoded from registered state only.

## Test plan
- After reset, then 13/4 with out_ready=1: in_ready=1 before acceptance; out_valid 4 cycles after acceptance with quotient=3, remainder=1, div_by_zero=0. in_ready returns 1 one cycle after the result.
- Boundaries, run as separate requests:
  - 15/1 → Q=15, R=0.
  - 3/7 → Q=0, R=3.
  - 0/5 → Q=0, R=0.
  - 15/15 → Q=1, R=0.
  - 8/3 → Q=2, R=2.
- 9/0 → out_valid on the cycle after acceptance with quotient=4'hF, remainder=9, div_by_zero=1. A following 6/2 gives Q=3, R=0 and div_by_zero=0.
- Backpressure on 14/3: hold out_ready=0 for 5 cycles → out_valid, Q=4 and R=2 stay stable and in_ready=0 throughout. Raise out_ready → out_valid drops on the next edge.
- While BUSY on 12/5, change dividend/divisor to 1/1 and pulse in_valid → the result is still Q=2, R=2, and no extra result appears.
- Drive rst_n=0 for one edge at iteration 2 of 11/2 → all outputs are 0 and in_ready=1 after that edge, with no out_valid. A new 11/2 then gives Q=5, R=1.
- Exhaustive sweep of all 256 dividend/divisor pairs, with random out_ready stalls, checked against a reference model.
